// File: rtl/iter_done_ctrl_if.sv
// Bus bundle for iter_done_ctrl: iteration control inputs and completion status outputs.
// master drives the controls (testbench or host); slave is the controller itself.
interface iter_done_ctrl_if #(
    parameter int NCH    = 4,
    parameter int ITER_W = 8
);
    logic              enable;
    logic [NCH-1:0]    dividor_done;
    logic              Y_eof_reg;
    logic [ITER_W-1:0] max_iter;
    logic              clear_count;
    logic              iter_done;
    logic              done_pulse;
    logic [ITER_W-1:0] iter_count;
    logic              limit_hit;
    logic              timeout;

    modport master (
        output enable, dividor_done, Y_eof_reg, max_iter, clear_count,
        input  iter_done, done_pulse, iter_count, limit_hit, timeout
    );

    modport slave (
        input  enable, dividor_done, Y_eof_reg, max_iter, clear_count,
        output iter_done, done_pulse, iter_count, limit_hit, timeout
    );
endinterface

// File: rtl/iter_done_ctrl.sv
// Iteration completion controller: waits for every divider channel plus the delayed Y end-of-frame.
// Optional macro ITER_DONE_WATCHDOG_EN adds a RUN-state watchdog that forces completion after TIMEOUT cycles.
module iter_done_ctrl #(
    parameter int NCH     = 4,
    parameter int DELAY   = 13,
    parameter int ITER_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    iter_done_ctrl_if.slave  bus
);

    if (NCH < 1 || NCH > 16 || DELAY < 1 || DELAY > 64 || TIMEOUT < 1) begin : g_bad_param
        $error("iter_done_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DELAY-1:0]  dly_q, dly_d;
    logic [NCH-1:0]    ch_seen_q, ch_seen_d;
    logic              eof_seen_q, eof_seen_d;
    logic              iter_done_q, iter_done_d;
    logic              done_pulse_q, done_pulse_d;
    logic [ITER_W-1:0] iter_count_q, iter_count_d;
    logic              eof_dly;
    logic              done_cond;
    logic              wd_expire;

`ifdef ITER_DONE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    assign wd_expire = (state_q == RUN) && (wd_q == WD_W'(TIMEOUT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // Oldest delay-line tap is the Y end-of-frame seen DELAY cycles ago.
    assign eof_dly   = dly_q[DELAY-1];
    assign done_cond = (state_q == RUN) && (&(ch_seen_q | bus.dividor_done))
                       && (eof_seen_q || eof_dly);

    always_comb begin
        dly_d[0] = bus.Y_eof_reg;
        for (int i = 1; i < DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
        end

        state_d      = state_q;
        ch_seen_d    = ch_seen_q;
        eof_seen_d   = eof_seen_q;
        iter_done_d  = iter_done_q;
        done_pulse_d = done_pulse_q;
        iter_count_d = iter_count_q;
`ifdef ITER_DONE_WATCHDOG_EN
        timeout_d    = timeout_q;
`endif

        if (!bus.enable) begin
            state_d      = IDLE;
            ch_seen_d    = '0;
            eof_seen_d   = 1'b0;
            iter_done_d  = 1'b0;
            done_pulse_d = 1'b0;
`ifdef ITER_DONE_WATCHDOG_EN
            timeout_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (done_cond) begin
                        state_d      = DONE;
                        iter_done_d  = 1'b1;
                        done_pulse_d = 1'b1;
                        if (iter_count_q != {ITER_W{1'b1}}) begin
                            iter_count_d = iter_count_q + 1'b1;
                        end
                    end else if (wd_expire) begin
                        // Forced completion: flagged, but not counted as an iteration.
                        state_d      = DONE;
                        iter_done_d  = 1'b1;
                        done_pulse_d = 1'b1;
`ifdef ITER_DONE_WATCHDOG_EN
                        timeout_d    = 1'b1;
`endif
                    end else begin
                        ch_seen_d  = ch_seen_q | bus.dividor_done;
                        eof_seen_d = eof_seen_q | eof_dly;
                    end
                end
                DONE:    done_pulse_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end

        if (bus.clear_count) begin
            iter_count_d = '0;
        end

`ifdef ITER_DONE_WATCHDOG_EN
        wd_d = (state_q == RUN && state_d == RUN) ? wd_q + 1'b1 : '0;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dly_q        <= '0;
            ch_seen_q    <= '0;
            eof_seen_q   <= 1'b0;
            iter_done_q  <= 1'b0;
            done_pulse_q <= 1'b0;
            iter_count_q <= '0;
`ifdef ITER_DONE_WATCHDOG_EN
            timeout_q    <= 1'b0;
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            ch_seen_q    <= ch_seen_d;
            eof_seen_q   <= eof_seen_d;
            iter_done_q  <= iter_done_d;
            done_pulse_q <= done_pulse_d;
            iter_count_q <= iter_count_d;
`ifdef ITER_DONE_WATCHDOG_EN
            timeout_q    <= timeout_d;
            wd_q         <= wd_d;
`endif
        end
    end

    assign bus.iter_done  = iter_done_q;
    assign bus.done_pulse = done_pulse_q;
    assign bus.iter_count = iter_count_q;
    assign bus.limit_hit  = (bus.max_iter != '0) && (iter_count_q >= bus.max_iter);
`ifdef ITER_DONE_WATCHDOG_EN
    assign bus.timeout    = timeout_q;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_iter_done_ctrl.sv
// Self-checking bench for iter_done_ctrl: scenario table, directed corner sequences and
// randomized traffic compared every cycle against a behavioural model.
module tb_iter_done_ctrl;
    localparam int NCH    = 4;
    localparam int DELAY  = 13;
    localparam int ITER_W = 8;
    localparam int MAXC   = (1 << ITER_W) - 1;
`ifdef ITER_DONE_WATCHDOG_EN
    localparam int TIMEOUT = 48;
    localparam bit WD      = 1'b1;
`else
    localparam int TIMEOUT = 1024;
    localparam bit WD      = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    iter_done_ctrl_if #(.NCH(NCH), .ITER_W(ITER_W)) bus ();

    iter_done_ctrl #(.NCH(NCH), .DELAY(DELAY), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: Y history queue plus per-iteration bookkeeping.
    bit m_hist[$];
    bit m_run, m_done, m_eof, m_pulse, m_tmo;
    bit [NCH-1:0] m_seen;
    int m_cnt, m_runcyc;

    typedef struct {
        int ch0; int ch1; int ch2; int ch3;
        int ch_len;
        int y_t;
        int exp_rise;
    } scn_t;
    scn_t scn[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DELAY; i++) m_hist.push_back(1'b0);
        m_run = 0; m_done = 0; m_eof = 0; m_pulse = 0; m_tmo = 0;
        m_seen = '0; m_cnt = 0; m_runcyc = 0;
    endtask

    task automatic model_edge();
        bit eofd;
        bit dummy;
        eofd = m_hist[0];
        if (!bus.enable) begin
            m_run = 0; m_done = 0; m_eof = 0; m_pulse = 0; m_tmo = 0;
            m_seen = '0; m_runcyc = 0;
        end else if (!m_run && !m_done) begin
            m_run = 1; m_runcyc = 0;
        end else if (m_done) begin
            m_pulse = 0;
        end else if (((m_seen | bus.dividor_done) == {NCH{1'b1}}) && (m_eof || eofd)) begin
            m_run = 0; m_done = 1; m_pulse = 1;
            if (m_cnt < MAXC) m_cnt = m_cnt + 1;
        end else if (WD && (m_runcyc + 1 >= TIMEOUT)) begin
            m_run = 0; m_done = 1; m_pulse = 1; m_tmo = 1;
        end else begin
            m_seen = m_seen | bus.dividor_done;
            m_eof  = m_eof | eofd;
            m_runcyc = m_runcyc + 1;
        end
        if (bus.clear_count) m_cnt = 0;
        m_hist.push_back(bus.Y_eof_reg);
        dummy = m_hist.pop_front();
    endtask

    task automatic check_outputs(input string name);
        logic exp_lim;
        exp_lim = (bus.max_iter != '0) && (m_cnt >= int'(bus.max_iter));
        check(name, {20'd0, bus.iter_done, bus.done_pulse, bus.iter_count, bus.limit_hit, bus.timeout},
              {20'd0, m_done, m_pulse, ITER_W'(m_cnt), exp_lim, m_tmo});
    endtask

    // Advance one clock; inputs are already driven for this cycle.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs("cycle_outputs");
    endtask

    task automatic idle_flush(input logic y_level);
        bus.enable = 1'b0; bus.dividor_done = '0; bus.Y_eof_reg = y_level;
        repeat (DELAY + 1) step();
    endtask

    task automatic run_scn(input int idx);
        int ct[4];
        int rise;
        int cnt0;
        ct[0] = scn[idx].ch0; ct[1] = scn[idx].ch1; ct[2] = scn[idx].ch2; ct[3] = scn[idx].ch3;
        idle_flush(1'b0);
        rise = -1;
        cnt0 = int'(bus.iter_count);
        for (int t = 0; t < 40; t++) begin
            bus.enable = 1'b1;
            for (int i = 0; i < NCH; i++)
                bus.dividor_done[i] = (t >= ct[i]) && (t < ct[i] + scn[idx].ch_len);
            bus.Y_eof_reg = (t == scn[idx].y_t);
            step();
            if (rise < 0 && bus.iter_done) rise = t + 1;
        end
        check($sformatf("scn%0d_rise", idx), rise, scn[idx].exp_rise);
        check($sformatf("scn%0d_count_delta", idx), int'(bus.iter_count) - cnt0,
              (scn[idx].exp_rise >= 0) ? 1 : 0);
    endtask

    // One enable-low cycle, then enable with all channels and eof already present.
    task automatic quick_iter(input logic clr_on_done);
        bus.enable = 1'b0; bus.clear_count = 1'b0;
        step();
        bus.enable = 1'b1;
        step();
        bus.clear_count = clr_on_done;
        step();
        bus.clear_count = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        scn[0] = '{5, 5, 5, 5, 1, 10, 24};
        scn[1] = '{3, 7, 9, 20, 1, 2, 21};
        scn[2] = '{0, 0, 0, 0, 1, 1, -1};
        scn[3] = '{2, 2, 2, 12, 19, 4, 18};
        scn[4] = '{0, 0, 0, 0, 2, 0, 14};

        bus.enable = 1'b0; bus.dividor_done = '0; bus.Y_eof_reg = 1'b0;
        bus.max_iter = '0; bus.clear_count = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_state");
        rst_n = 1'b1;

        for (int s = 0; s < 5; s++) run_scn(s);

        // Asynchronous reset in the middle of RUN with three channels recorded.
        bus.enable = 1'b0; step();
        bus.enable = 1'b1; step();
        bus.dividor_done = 4'b0111; step();
        bus.dividor_done = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_outputs",
              {27'd0, bus.iter_done, bus.done_pulse, bus.limit_hit, bus.timeout, |bus.iter_count}, 32'd0);
        @(posedge clk);
        #1;
        check_outputs("reset_held");
        rst_n = 1'b1;

        // Clear coincident with completion at count 5.
        bus.dividor_done = 4'b1111;
        idle_flush(1'b1);
        bus.dividor_done = 4'b1111;
        for (int k = 0; k < 5; k++) quick_iter(1'b0);
        check("count_before_clear", bus.iter_count, 5);
        quick_iter(1'b1);
        check("clear_wins_count", bus.iter_count, 0);
        check("clear_wins_done", bus.iter_done, 1);

        // Saturation and limit flag.
        bus.max_iter = ITER_W'(10);
        for (int k = 0; k < 260; k++) quick_iter(1'b0);
        check("count_saturated", bus.iter_count, MAXC);
        check("limit_hit_high", bus.limit_hit, 1);
        bus.max_iter = '0;
        #1;
        check("limit_hit_nolimit", bus.limit_hit, 0);

        // RUN with no divider activity: watchdog fires only when enabled.
        bus.clear_count = 1'b1; bus.enable = 1'b0; bus.dividor_done = '0; bus.Y_eof_reg = 1'b0;
        step();
        bus.clear_count = 1'b0;
        idle_flush(1'b0);
        bus.enable = 1'b1;
        repeat (TIMEOUT + 3 > 60 ? 60 : TIMEOUT + 3) step();
        check("stall_iter_done", bus.iter_done, WD);
        check("stall_timeout", bus.timeout, WD);
        check("stall_count", bus.iter_count, 0);
        bus.enable = 1'b0;
        step();
        check("timeout_cleared", bus.timeout, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            bus.enable = ($urandom_range(0, 99) < 95);
            for (int i = 0; i < NCH; i++) bus.dividor_done[i] = ($urandom_range(0, 9) == 0);
            bus.Y_eof_reg = ($urandom_range(0, 19) == 0);
            bus.clear_count = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) bus.max_iter = ITER_W'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/iter_done_ctrl.md
ITER_DONE_CTRL -- requirements
Module: iter_done_ctrl

Interface
REQ-001 Parameter: NCH, 4, number of divider channels whose done strobes must all be seen (1..16).
REQ-002 Parameter: DELAY, 13, number of register stages on Y_eof_reg before use (1..64).
REQ-003 Parameter: ITER_W, 8, width of iteration counter and max_iter.
REQ-004 Parameter: TIMEOUT, 1024, watchdog cycle limit in RUN (used only with the Configuration macro).
REQ-005 clock  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-007 enable  input  1  high = iteration armed; low = abort/clear iteration state.
REQ-008 dividor_done  input  NCH  per-channel divider done strobe, may be single-cycle or level.
REQ-009 Y_eof_reg  input  1  end-of-frame marker of the Y stream, undelayed.
REQ-010 max_iter  input  ITER_W  iteration limit; 0 = no limit.
REQ-011 clear_count  input  1  synchronous clear of iter_count.
REQ-012 iter_done  output  1  registered; high = current iteration complete.
REQ-013 done_pulse  output  1  registered; single-cycle strobe on iter_done rising.
REQ-014 iter_count  output  ITER_W  completed-iteration count, saturating.
REQ-015 limit_hit  output  1  high while max_iter!=0 and iter_count>=max_iter.
REQ-016 timeout  output  1  watchdog expiry flag (see Configuration).

Function
REQ-017 Delay line: eof_d SHALL equal Y_eof_reg delayed exactly DELAY cycles; delay line runs regardless of enable.
REQ-018 States: IDLE, RUN, DONE; IDLE->RUN on edge with enable=1; any state->IDLE on edge with enable=0.
REQ-019 RUN: sticky flag ch_seen[i] SHALL set on any cycle dividor_done[i]=1; sticky eof_seen SHALL set on eof_d=1.
REQ-020 done_cond = &(ch_seen | dividor_done) and (eof_seen or eof_d), evaluated in RUN only.
REQ-021 RUN->DONE on the edge where done_cond=1; iter_done and done_pulse high from that edge (latency 1 cycle from done_cond).
REQ-022 DONE: iter_done held high, done_pulse low after one cycle, inputs ignored, until enable=0.
REQ-023 On entry to IDLE: ch_seen, eof_seen, iter_done, done_pulse cleared on that edge.
REQ-024 iter_count SHALL increment by 1 on each RUN->DONE edge; saturate at 2^ITER_W-1, no wrap.
REQ-025 clear_count=1 SHALL zero iter_count; if coincident with RUN->DONE, clear wins (result 0).
REQ-026 Strobes arriving in IDLE or DONE SHALL not be recorded; eof_d and dividor_done coincident with IDLE->RUN edge are not recorded (first recorded cycle is first RUN cycle).
REQ-027 enable dropping in the same cycle as done_cond: IDLE wins, no iteration counted.
REQ-028 limit_hit combinational from iter_count and max_iter, no added latency.

Reset
REQ-029 reset=0: state IDLE, delay line all 0, ch_seen=0, eof_seen=0, iter_done=0, done_pulse=0, iter_count=0, timeout=0, watchdog=0.
REQ-030 Reset mid-RUN or mid-DONE SHALL abort without incrementing iter_count; first activity resumes on first edge after reset=1.

Configuration
REQ-031 Macro ITER_DONE_WATCHDOG_EN defined: cycle counter increments each RUN cycle, clears on leaving RUN; reaching TIMEOUT forces RUN->DONE with iter_done=1, done_pulse=1, timeout=1, iter_count not incremented; timeout clears with iter_done.
REQ-032 Macro undefined: no watchdog logic, timeout tied 0, TIMEOUT ignored, RUN waits indefinitely.

Verification
REQ-033 NCH=4, DELAY=13: enable=1, dividor_done=4'b1111 for 1 cycle at t=5, Y_eof_reg pulse at t=10 -> eof_d at t=23, iter_done and done_pulse rise at t=24, iter_count=1.
REQ-034 Channels done on different cycles (bit0 t=3, bit1 t=7, bit2 t=9, bit3 t=20), eof_d at t=15 -> iter_done rises t=21.
REQ-035 enable toggled 0 for one cycle then 1, repeated 255 times with immediate completion, ITER_W=8 -> iter_count saturates at 255; max_iter=10 -> limit_hit high from count 10.
REQ-036 Assert reset=0 asynchronously at mid-RUN with ch_seen=4'b0111 -> all outputs 0 immediately, no count increment.
REQ-037 With ITER_DONE_WATCHDOG_EN, TIMEOUT=16, no dividor_done -> after 16 RUN cycles iter_done=1, timeout=1, iter_count unchanged; without macro, iter_done stays 0.
REQ-038 clear_count=1 coincident with RUN->DONE edge at iter_count=5 -> iter_count=0, iter_done=1.
